// File: rtl/ucode_pkg.sv
// Shared types and constants for the microprogram sequencer: sequencing modes,
// opcode dispatch tables and the default 11-state multicycle control program.
package ucode_pkg;

  localparam int SEQ_W       = 3;
  localparam int DEF_CTRL_W  = 13;
  localparam int DEF_UADDR_W = 5;
  localparam int NUM_DEFAULT = 11;

  typedef enum logic [2:0] {
    NEXT   = 3'b000,
    DISP1  = 3'b001,
    DISP2  = 3'b010,
    FETCH  = 3'b011,
    JUMP   = 3'b100,
    BRCOND = 3'b101,
    CALL   = 3'b110,
    RET    = 3'b111
  } seq_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // Microword layout is {ctrl, seq, target}; positions are relative to UADDR_W
  function automatic int seq_lsb(input int uaddr_w);
    return uaddr_w;
  endfunction

  function automatic int ctrl_lsb(input int uaddr_w);
    return uaddr_w + SEQ_W;
  endfunction

  typedef struct packed {
    logic [6:0]             opcode;
    logic [DEF_UADDR_W-1:0] target;
  } disp_entry_t;

  typedef struct packed {
    logic                   hit;
    logic [DEF_UADDR_W-1:0] target;
  } disp_result_t;

  localparam disp_entry_t DISP1_MAP [6] = '{
    '{OP_LW,    5'd2}, '{OP_SW,  5'd2}, '{OP_RTYPE, 5'd6},
    '{OP_IALU,  5'd8}, '{OP_JAL, 5'd9}, '{OP_BEQ,   5'd10}
  };

  localparam disp_entry_t DISP2_MAP [2] = '{'{OP_LW, 5'd3}, '{OP_SW, 5'd5}};

  function automatic disp_result_t disp1_lookup(input logic [6:0] op);
    disp_result_t res;
    res = '0;
    for (int i = 0; i < 6; i++)
      if (DISP1_MAP[i].opcode == op) res = '{hit: 1'b1, target: DISP1_MAP[i].target};
    return res;
  endfunction

  function automatic disp_result_t disp2_lookup(input logic [6:0] op);
    disp_result_t res;
    res = '0;
    for (int i = 0; i < 2; i++)
      if (DISP2_MAP[i].opcode == op) res = '{hit: 1'b1, target: DISP2_MAP[i].target};
    return res;
  endfunction

  // Control field order: PCUpdate RegWrite MemWrite IRWrite AdrSrc ResultSrc ALUSrcA ALUSrcB ALUOp
  function automatic logic [DEF_CTRL_W-1:0] mk_ctrl(
    input logic       pcupdate, regwrite, memwrite, irwrite, adrsrc,
    input logic [1:0] resultsrc, alusrca, alusrcb, aluop
  );
    return {pcupdate, regwrite, memwrite, irwrite, adrsrc, resultsrc, alusrca, alusrcb, aluop};
  endfunction

  typedef struct packed {
    logic [DEF_CTRL_W-1:0]  ctrl;
    seq_e                   seq;
    logic [DEF_UADDR_W-1:0] target;
  } uword_t;

  localparam uword_t DEFAULT_UCODE [NUM_DEFAULT] = '{
    '{ctrl: mk_ctrl(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00), seq: NEXT,  target: 5'd0},
    '{ctrl: mk_ctrl(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00), seq: DISP1, target: 5'd0},
    '{ctrl: mk_ctrl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00), seq: DISP2, target: 5'd0},
    '{ctrl: mk_ctrl(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00), seq: NEXT,  target: 5'd0},
    '{ctrl: mk_ctrl(0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00), seq: FETCH, target: 5'd0},
    '{ctrl: mk_ctrl(0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00), seq: FETCH, target: 5'd0},
    '{ctrl: mk_ctrl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10), seq: NEXT,  target: 5'd0},
    '{ctrl: mk_ctrl(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), seq: FETCH, target: 5'd0},
    '{ctrl: mk_ctrl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10), seq: JUMP,  target: 5'd7},
    '{ctrl: mk_ctrl(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00), seq: JUMP,  target: 5'd7},
    '{ctrl: mk_ctrl(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01), seq: FETCH, target: 5'd0}
  };

  function automatic uword_t default_uword(input int idx);
    uword_t w;
    w = '0;
    for (int i = 0; i < NUM_DEFAULT; i++)
      if (i == idx) w = DEFAULT_UCODE[i];
    return w;
  endfunction

endpackage

// File: rtl/ucode_ret_stack.sv
// Micro-call return-address LIFO; requests that would overflow or underflow are
// ignored here and reported by the sequencer through full/empty.
module ucode_ret_stack #(
  parameter int UADDR_W     = 5,
  parameter int STACK_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [UADDR_W-1:0] din,
  output logic [UADDR_W-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int PW = $clog2(STACK_DEPTH + 1);

  logic [PW-1:0]      sp;
  logic [UADDR_W-1:0] mem [STACK_DEPTH];

  assign full  = (int'(sp) == STACK_DEPTH);
  assign empty = (sp == '0);

  always_comb begin
    dout = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (int'(sp) == i + 1) dout = mem[i];
  end

  always_ff @(posedge clk) begin
    if (reset)                sp <= '0;
    else if (push && !full)   sp <= sp + 1'b1;
    else if (pop && !empty)   sp <= sp - 1'b1;
  end

  // Entries need no reset; sp alone decides what is valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++)
      if (push && !full && int'(sp) == i) mem[i] <= din;
  end

endmodule

// File: rtl/ucode_sequencer.sv
// Microprogram sequencer: writable control store, micro-PC, opcode dispatch,
// conditional micro-branch and call/return via ucode_ret_stack.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int CTRL_W      = 13,
  parameter int UADDR_W     = 5,
  parameter int DEPTH       = 32,
  parameter int STACK_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              stall,
  input  logic [6:0]                        opcode,
  input  logic                              cond,
  input  logic                              we,
  input  logic [UADDR_W-1:0]                waddr,
  input  logic [CTRL_W+SEQ_W+UADDR_W-1:0]   wdata,
  output logic [CTRL_W-1:0]                 ctrl,
  output logic [UADDR_W-1:0]                upc,
  output logic                              illegal_op,
  output logic                              stack_err
);

  localparam int MW      = CTRL_W + SEQ_W + UADDR_W;
  localparam int SEQ_LSB = seq_lsb(UADDR_W);
  localparam int CTL_LSB = ctrl_lsb(UADDR_W);

  function automatic logic [MW-1:0] init_word(input int idx);
    uword_t d;
    d = default_uword(idx);
    return {CTRL_W'(d.ctrl), d.seq, UADDR_W'(d.target)};
  endfunction

  logic [MW-1:0] store_rd [DEPTH];

  // The store is loaded from the default program at power-up only; reset leaves it alone
  for (genvar i = 0; i < DEPTH; i++) begin : g_store
    logic [MW-1:0] word = init_word(i);
    always_ff @(posedge clk)
      if (we && waddr == UADDR_W'(i)) word <= wdata;
    assign store_rd[i] = word;
  end

  logic               in_range;
  logic [MW-1:0]      cur_word;
  seq_e               cur_seq;
  logic [UADDR_W-1:0] cur_target, upc_inc, upc_next, stk_top;
  logic               do_push, do_pop, err_set, illegal, stk_full, stk_empty;
  disp_result_t       d1, d2;

  assign in_range   = (int'(upc) < DEPTH);
  assign cur_word   = in_range ? store_rd[upc] : '0;
  assign cur_seq    = in_range ? seq_e'(cur_word[SEQ_LSB +: SEQ_W]) : FETCH;
  assign cur_target = cur_word[UADDR_W-1:0];
  assign ctrl       = cur_word[CTL_LSB +: CTRL_W];
  assign upc_inc    = upc + 1'b1;
  assign d1         = disp1_lookup(opcode);
  assign d2         = disp2_lookup(opcode);
  assign illegal_op = illegal;

  always_comb begin
    upc_next = upc_inc;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    err_set  = 1'b0;
    illegal  = 1'b0;
    case (cur_seq)
      NEXT:   upc_next = upc_inc;
      DISP1:  if (d1.hit) upc_next = UADDR_W'(d1.target);
              else begin upc_next = '0; illegal = 1'b1; end
      DISP2:  if (d2.hit) upc_next = UADDR_W'(d2.target);
              else begin upc_next = '0; illegal = 1'b1; end
      FETCH:  upc_next = '0;
      JUMP:   upc_next = cur_target;
      BRCOND: upc_next = cond ? cur_target : upc_inc;
      // A call on a full stack still jumps; only the return address is lost
      CALL: begin
        upc_next = cur_target;
        if (stk_full) err_set = 1'b1;
        else          do_push = 1'b1;
      end
      RET: begin
        if (stk_empty) begin upc_next = '0; err_set = 1'b1; end
        else begin upc_next = stk_top; do_pop = 1'b1; end
      end
      default: upc_next = '0;
    endcase
  end

  ucode_ret_stack #(
    .UADDR_W     (UADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (do_push && !stall),
    .pop   (do_pop && !stall),
    .din   (upc_inc),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      upc       <= '0;
      stack_err <= 1'b0;
    end else if (!stall) begin
      upc <= upc_next;
      if (err_set) stack_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Scoreboard bench for ucode_sequencer: stimulus queues expected state per cycle,
// a negedge monitor pops and compares upc, ctrl, illegal_op and stack_err.
module tb_ucode_sequencer;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] RTY  = 7'b0110011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BAD  = 7'b1111111;
  localparam logic [2:0] Q_JUMP = 3'b100, Q_BR = 3'b101, Q_CALL = 3'b110, Q_RET = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [6:0]  opcode = LW;
  logic        cond = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [20:0] wdata = '0;
  logic [12:0] ctrl;
  logic [4:0]  upc;
  logic        illegal_op, stack_err;

  ucode_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .opcode     (opcode),
    .cond       (cond),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .ctrl       (ctrl),
    .upc        (upc),
    .illegal_op (illegal_op),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int step;
    int upc;
    int ctrl;
    int ill;
    int err;
  } exp_t;

  exp_t        expQ [$];
  int          passCount = 0;
  int          totalCount = 0;
  int          stepNo = 0;
  logic        pendWe = 1'b0;
  logic [4:0]  pendAddr = '0;
  logic [20:0] pendData = '0;

  function automatic logic [20:0] mkword(input logic [12:0] c, input logic [2:0] s, input logic [4:0] t);
    return {c, s, t};
  endfunction

  task automatic queueWrite(input logic [4:0] a, input logic [20:0] d);
    pendWe = 1'b1; pendAddr = a; pendData = d;
  endtask

  // Drive one cycle of inputs and record the state the DUT must show during it
  task automatic applyStimulus(input logic rst, input logic st, input logic [6:0] op, input logic c,
                               input int eupc, input int ectrl, input int eill, input int eerr);
    exp_t e;
    @(posedge clk); #1;
    reset = rst; stall = st; opcode = op; cond = c;
    we = pendWe; waddr = pendAddr; wdata = pendData; pendWe = 1'b0;
    stepNo++;
    e.step = stepNo; e.upc = eupc; e.ctrl = ectrl; e.ill = eill; e.err = eerr;
    expQ.push_back(e);
  endtask

  task automatic cmpField(input int step, input string name, input logic [31:0] got, input int want);
    if (want >= 0) begin
      totalCount++;
      if (got === want) passCount++;
      else $display("[TB] FAIL step%0d %s: got 0x%0h want 0x%0h", step, name, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmpField(e.step, "upc", 32'(upc), e.upc);
    cmpField(e.step, "ctrl", 32'(ctrl), e.ctrl);
    cmpField(e.step, "illegal_op", 32'(illegal_op), e.ill);
    cmpField(e.step, "stack_err", 32'(stack_err), e.err);
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    // lw: 0,1,2,3,4,0
    applyStimulus(0, 0, LW, 0, 0, 'h1288, 0, 0);
    applyStimulus(0, 0, LW, 0, 1, 'h0014, 0, 0);
    applyStimulus(0, 0, LW, 0, 2, 'h0024, 0, 0);
    applyStimulus(0, 0, LW, 0, 3, 'h0100, 0, 0);
    applyStimulus(0, 0, LW, 0, 4, 'h0840, 0, 0);
    // R-type: 0,1,6,7,0
    applyStimulus(0, 0, RTY, 0, 0, 'h1288, 0, 0);
    applyStimulus(0, 0, RTY, 0, 1, 'h0014, 0, 0);
    applyStimulus(0, 0, RTY, 0, 6, 'h0022, 0, 0);
    applyStimulus(0, 0, RTY, 0, 7, 'h0800, 0, 0);
    // unmapped opcode
    applyStimulus(0, 0, BAD, 0, 0, 'h1288, 0, 0);
    applyStimulus(0, 0, BAD, 0, 1, 'h0014, 1, 0);
    // stall at upc 3 for five cycles
    applyStimulus(0, 0, LW, 0, 0, 'h1288, 0, 0);
    applyStimulus(0, 0, LW, 0, 1, 'h0014, 0, 0);
    applyStimulus(0, 0, LW, 0, 2, 'h0024, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, LW, 0, 3, 'h0100, 0, 0);
    applyStimulus(0, 0, LW, 0, 3, 'h0100, 0, 0);
    applyStimulus(0, 0, LW, 0, 4, 'h0840, 0, 0);
    // rewrite entry 0 while executing it: old word this cycle, new word next visit
    queueWrite(5'd0, mkword(13'h0AA, Q_JUMP, 5'd20));
    applyStimulus(0, 0, JAL, 0, 0, 'h1288, 0, 0);
    queueWrite(5'd20, mkword(13'h000, Q_BR, 5'd25));
    applyStimulus(0, 0, JAL, 0, 1, 'h0014, 0, 0);
    applyStimulus(0, 0, JAL, 0, 9, 'h1018, 0, 0);
    applyStimulus(0, 0, JAL, 0, 7, 'h0800, 0, 0);
    applyStimulus(0, 0, LW, 0, 0, 'h00AA, 0, 0);
    applyStimulus(0, 0, LW, 1, 20, 'h0000, 0, 0);
    for (int a = 25; a <= 31; a++) applyStimulus(0, 0, LW, 0, a, 'h0000, 0, 0);
    applyStimulus(0, 0, LW, 0, 0, 'h00AA, 0, 0);
    applyStimulus(0, 0, LW, 0, 20, 'h0000, 0, 0);
    applyStimulus(0, 0, LW, 0, 21, 'h0000, 0, 0);
    // walk 22..31 while loading the nested-call program
    for (int a = 22; a <= 31; a++) begin
      case (a)
        22: queueWrite(5'd0,  mkword(13'h000, Q_JUMP, 5'd12));
        23: queueWrite(5'd12, mkword(13'h011, Q_CALL, 5'd14));
        24: queueWrite(5'd14, mkword(13'h012, Q_CALL, 5'd16));
        25: queueWrite(5'd16, mkword(13'h013, Q_CALL, 5'd18));
        26: queueWrite(5'd18, mkword(13'h014, Q_RET,  5'd0));
        27: queueWrite(5'd15, mkword(13'h015, Q_RET,  5'd0));
        28: queueWrite(5'd13, mkword(13'h016, Q_RET,  5'd0));
        default: ;
      endcase
      applyStimulus(0, 0, LW, 0, a, 'h0000, 0, 0);
    end
    // three nested calls on a two-deep stack, then three returns
    applyStimulus(0, 0, LW, 0, 0, 'h0000, 0, 0);
    queueWrite(5'd0, mkword(13'h155, Q_CALL, 5'd6));
    applyStimulus(0, 0, LW, 0, 12, 'h0011, 0, 0);
    applyStimulus(0, 0, LW, 0, 14, 'h0012, 0, 0);
    applyStimulus(0, 0, LW, 0, 16, 'h0013, 0, 0);
    applyStimulus(0, 0, LW, 0, 18, 'h0014, 0, 1);
    applyStimulus(0, 0, LW, 0, 15, 'h0015, 0, 1);
    applyStimulus(0, 0, LW, 0, 13, 'h0016, 0, 1);
    applyStimulus(0, 0, LW, 0, 0, 'h0155, 0, 1);
    // reset at upc 7 with one return address pending
    queueWrite(5'd0, mkword(13'h0F0, Q_RET, 5'd0));
    applyStimulus(0, 0, LW, 0, 6, 'h0022, 0, 1);
    applyStimulus(1, 1, LW, 0, 7, 'h0800, 0, 1);
    applyStimulus(0, 0, LW, 0, 0, 'h00F0, 0, 0);
    applyStimulus(0, 0, LW, 0, 0, 'h00F0, 0, 1);

    for (int k = 0; k < 5 && expQ.size() > 0; k++) begin
      @(negedge clk); #1;
    end
    if (expQ.size() > 0) begin
      totalCount++;
      $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
